// File: rtl/mmss_timer_disp.sv
// MM:SS up/down timer with start/stop/clear/load and a multiplexed seven-segment scanner.
// Optional BLINK_EN: flashes the display while the timer sits expired.
module mmss_timer_disp #(
   parameter int TICK_DIV     = 100000000,
   parameter int SCAN_DIV     = 100000,
   parameter int NUM_AN       = 8,
   parameter int COMMON_ANODE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              clr,
   input  logic              load,
   input  logic [15:0]       load_val,
   input  logic              down,
   output logic [NUM_AN-1:0] AN,
   output logic [7:1]        seg,
   output logic [15:0]       bcd,
   output logic              tick,
   output logic              done
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [2:0]         IDX_MAX   = 3'(NUM_AN - 1);
   localparam logic [NUM_AN-1:0]  AN_OFF    = (COMMON_ANODE != 0) ? {NUM_AN{1'b1}} : {NUM_AN{1'b0}};
   localparam logic [7:1]         SEG_OFF   = (COMMON_ANODE != 0) ? 7'h7F : 7'h00;

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUNNING = 2'd1,
      ST_EXPIRED = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [PRESC_W-1:0]   presc_q, presc_d;
   logic [15:0]          digits_q, digits_d;
   logic                 tick_q, tick_d;
   logic                 done_q;
   logic [SCAN_W-1:0]    scan_q, scan_d;
   logic [2:0]           idx_q, idx_d;
   logic [NUM_AN-1:0]    an_q, an_d, an_act_s;
   logic [7:1]           seg_q, seg_d, seg_act_s;
   logic                 scan_wrap_s;
   logic                 blank_s;

   function automatic logic [3:0] sat_nib(input logic [3:0] v, input logic [3:0] lim);
      if (v > lim) begin
         return lim;
      end else begin
         return v;
      end
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] d);
      logic [3:0] s0, s1, m0, m1;
      {m1, m0, s1, s0} = d;
      if (s0 != 4'd9) begin
         s0 = s0 + 4'd1;
      end else begin
         s0 = 4'd0;
         if (s1 != 4'd5) begin
            s1 = s1 + 4'd1;
         end else begin
            s1 = 4'd0;
            if (m0 != 4'd9) begin
               m0 = m0 + 4'd1;
            end else begin
               m0 = 4'd0;
               if (m1 != 4'd5) begin
                  m1 = m1 + 4'd1;
               end else begin
                  m1 = 4'd0;
               end
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction

   function automatic logic [15:0] bcd_dec(input logic [15:0] d);
      logic [3:0] s0, s1, m0, m1;
      {m1, m0, s1, s0} = d;
      if (s0 != 4'd0) begin
         s0 = s0 - 4'd1;
      end else begin
         s0 = 4'd9;
         if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
         end else begin
            s1 = 4'd5;
            if (m0 != 4'd0) begin
               m0 = m0 - 4'd1;
            end else begin
               m0 = 4'd9;
               if (m1 != 4'd0) begin
                  m1 = m1 - 4'd1;
               end else begin
                  m1 = 4'd5;
               end
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction

   // Active-high segment pattern, bit order {g,f,e,d,c,b,a}.
   function automatic logic [7:1] seg_map(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   // Timer control: clr > load > stop > start > tick.
   always_comb begin
      state_d  = state_q;
      presc_d  = presc_q;
      digits_d = digits_q;
      tick_d   = 1'b0;
      if (clr) begin
         state_d  = ST_STOPPED;
         presc_d  = '0;
         digits_d = 16'h0000;
      end else if (load) begin
         state_d  = ST_STOPPED;
         presc_d  = '0;
         digits_d = {sat_nib(load_val[15:12], 4'd5), sat_nib(load_val[11:8], 4'd9),
                     sat_nib(load_val[7:4], 4'd5),   sat_nib(load_val[3:0], 4'd9)};
      end else begin
         case (state_q)
            ST_RUNNING: begin
               if (stop) begin
                  state_d = ST_STOPPED;
                  presc_d = '0;
               end else if (presc_q == PRESC_MAX) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
                  if (down) begin
                     // 00:00 while running expires without moving the digits.
                     if (digits_q == 16'h0000) begin
                        state_d = ST_EXPIRED;
                     end else begin
                        digits_d = bcd_dec(digits_q);
                        if (digits_q == 16'h0001) begin
                           state_d = ST_EXPIRED;
                        end else begin
                           state_d = ST_RUNNING;
                        end
                     end
                  end else begin
                     digits_d = bcd_inc(digits_q);
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end
            ST_STOPPED: begin
               presc_d = '0;
               if (stop) begin
                  state_d = ST_STOPPED;
               end else if (start) begin
                  state_d = ST_RUNNING;
               end else begin
                  state_d = ST_STOPPED;
               end
            end
            ST_EXPIRED: begin
               presc_d = '0;
            end
            default: begin
               state_d = ST_STOPPED;
               presc_d = '0;
            end
         endcase
      end
   end

   assign scan_wrap_s = (scan_q == SCAN_MAX);

   // Scan counter and digit index, free-running regardless of timer state.
   always_comb begin
      scan_d = scan_q;
      idx_d  = idx_q;
      if (scan_wrap_s) begin
         scan_d = '0;
         if (idx_q == IDX_MAX) begin
            idx_d = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         scan_d = scan_q + SCAN_W'(1);
      end
   end

   // Digit select and decode; indices 4 and up stay dark.
   always_comb begin
      an_act_s  = '0;
      seg_act_s = 7'b0000000;
      case (idx_q)
         3'd0: begin an_act_s[0] = 1'b1; seg_act_s = seg_map(digits_q[3:0]);   end
         3'd1: begin an_act_s[1] = 1'b1; seg_act_s = seg_map(digits_q[7:4]);   end
         3'd2: begin an_act_s[2] = 1'b1; seg_act_s = seg_map(digits_q[11:8]);  end
         3'd3: begin an_act_s[3] = 1'b1; seg_act_s = seg_map(digits_q[15:12]); end
         default: begin
            an_act_s  = '0;
            seg_act_s = 7'b0000000;
         end
      endcase
      if (blank_s) begin
         an_d = AN_OFF;
      end else begin
         an_d = (COMMON_ANODE != 0) ? ~an_act_s : an_act_s;
      end
      seg_d = (COMMON_ANODE != 0) ? ~seg_act_s : seg_act_s;
   end

`ifdef BLINK_EN
   logic [7:0] frame_q;
   logic       blink_q;
   logic       enter_exp_s;
   logic       frame_end_s;

   assign enter_exp_s = (state_q != ST_EXPIRED) && (state_d == ST_EXPIRED);
   assign frame_end_s = scan_wrap_s && (idx_q == IDX_MAX);
   assign blank_s     = (state_q == ST_EXPIRED) && blink_q;

   // Blink phase flips every 256 complete scan frames.
   always_ff @(posedge clk) begin
      if (rst || enter_exp_s) begin
         frame_q <= 8'd0;
         blink_q <= 1'b0;
      end else if (frame_end_s) begin
         frame_q <= frame_q + 8'd1;
         if (frame_q == 8'd255) begin
            blink_q <= ~blink_q;
         end else begin
            blink_q <= blink_q;
         end
      end else begin
         frame_q <= frame_q;
         blink_q <= blink_q;
      end
   end
`else
   assign blank_s = 1'b0;
`endif

   // State, timer and display registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_STOPPED;
         presc_q  <= '0;
         digits_q <= 16'h0000;
         tick_q   <= 1'b0;
         done_q   <= 1'b0;
         scan_q   <= '0;
         idx_q    <= 3'd0;
         an_q     <= AN_OFF;
         seg_q    <= SEG_OFF;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         digits_q <= digits_d;
         tick_q   <= tick_d;
         done_q   <= (state_d == ST_EXPIRED);
         scan_q   <= scan_d;
         idx_q    <= idx_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign AN   = an_q;
   assign seg  = seg_q;
   assign bcd  = digits_q;
   assign tick = tick_q;
   assign done = done_q;

endmodule
